// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer for a two-player pong game.
// Walks IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER). It keeps the
// score of each player and drives the ball/paddle datapath through
// engine_reset and engine_step. Every output comes straight from a register.
// Optional build macro: PONG_CTRL_PAUSE_EN enables the pause input. When the
// macro is not defined the pause port is still present but has no effect.
module pong_match_ctrl #(
    parameter int SERVE_FRAMES = 60,   // frame ticks spent holding the serve (1..255)
    parameter int WIN_SCORE    = 7     // points needed to win the match (1..15)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       pause,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       engine_reset,
    output logic       engine_step,
    output logic       serve_dir,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // The serve counter counts from 0, so the last tick of the hold is SERVE_FRAMES-1.
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [7:0] serve_cnt_q, serve_cnt_d;
    logic [3:0] score_left_q, score_left_d;
    logic [3:0] score_right_q, score_right_d;
    logic       serve_dir_q, serve_dir_d;
    logic       winner_q, winner_d;
    logic       engine_reset_q, engine_reset_d;
    logic       engine_step_q, engine_step_d;
    logic       game_over_q, game_over_d;

    logic       pause_act;

`ifdef PONG_CTRL_PAUSE_EN
    assign pause_act = pause;
`else
    // pause has no effect in this build. It is kept only so the port list
    // is the same in both builds.
    logic unused_pause;
    assign unused_pause = pause;
    assign pause_act    = 1'b0;
`endif

    // Next-state logic: state transitions, serve counter, scores and output values.
    always_comb begin
        state_d       = state_q;
        serve_cnt_d   = serve_cnt_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        serve_dir_d   = serve_dir_q;
        winner_d      = winner_q;
        engine_step_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    score_left_d  = 4'd0;
                    score_right_d = 4'd0;
                    serve_cnt_d   = 8'd0;
                    state_d       = ST_SERVE;
                end
            end

            ST_SERVE: begin
                // The counter moves only on frame ticks, so it holds its value between them.
                if (frame_tick && !pause_act) begin
                    if (serve_cnt_q == SERVE_LAST) begin
                        serve_cnt_d = 8'd0;
                        state_d     = ST_PLAY;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 8'd1;
                    end
                end
            end

            ST_PLAY: begin
                if (!pause_act) begin
                    // A miss takes priority over a frame tick in the same
                    // cycle. The frame that caused the miss is not stepped.
                    if (miss_left && miss_right) begin
                        state_d = ST_SERVE;
                    end else if (miss_left) begin
                        score_right_d = (score_right_q == 4'd15) ? score_right_q
                                                                 : score_right_q + 4'd1;
                        serve_dir_d   = 1'b0;
                        state_d       = ST_POINT;
                    end else if (miss_right) begin
                        score_left_d = (score_left_q == 4'd15) ? score_left_q
                                                               : score_left_q + 4'd1;
                        serve_dir_d  = 1'b1;
                        state_d      = ST_POINT;
                    end else if (frame_tick) begin
                        engine_step_d = 1'b1;
                    end
                end
            end

            ST_POINT: begin
                if (score_left_q == WIN_VAL) begin
                    winner_d = 1'b0;
                    state_d  = ST_OVER;
                end else if (score_right_q == WIN_VAL) begin
                    winner_d = 1'b1;
                    state_d  = ST_OVER;
                end else begin
                    state_d = ST_SERVE;
                end
            end

            ST_OVER: begin
                if (start) begin
                    score_left_d  = 4'd0;
                    score_right_d = 4'd0;
                    serve_cnt_d   = 8'd0;
                    state_d       = ST_SERVE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // These outputs are computed from the next state, so the registered
        // value matches state_o during the same cycle.
        engine_reset_d = (state_d != ST_PLAY);
        game_over_d    = (state_d == ST_OVER);
    end

    // State and output registers. The synchronous reset overrides every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            serve_cnt_q    <= 8'd0;
            score_left_q   <= 4'd0;
            score_right_q  <= 4'd0;
            serve_dir_q    <= 1'b0;
            winner_q       <= 1'b0;
            engine_reset_q <= 1'b1;
            engine_step_q  <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            serve_cnt_q    <= serve_cnt_d;
            score_left_q   <= score_left_d;
            score_right_q  <= score_right_d;
            serve_dir_q    <= serve_dir_d;
            winner_q       <= winner_d;
            engine_reset_q <= engine_reset_d;
            engine_step_q  <= engine_step_d;
            game_over_q    <= game_over_d;
        end
    end

    assign engine_reset = engine_reset_q;
    assign engine_step  = engine_step_q;
    assign serve_dir    = serve_dir_q;
    assign score_left   = score_left_q;
    assign score_right  = score_right_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;
    assign state_o      = state_q;

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 The block SHALL have parameter SERVE_FRAMES, default 60, which sets the number of frame ticks in the serve hold (1..255).
REQ-002 The block SHALL have parameter WIN_SCORE, default 7, which sets the points needed to win (1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port frame_tick, input, 1 bit: one-cycle strobe, once per game frame.
REQ-006 The block SHALL have port start, input, 1 bit: level; starts or restarts a match.
REQ-007 The block SHALL have port pause, input, 1 bit: level; freezes play (see Configuration).
REQ-008 The block SHALL have port miss_left, input, 1 bit: one-cycle pulse; the ball passed the left paddle.
REQ-009 The block SHALL have port miss_right, input, 1 bit: one-cycle pulse; the ball passed the right paddle.
REQ-010 The block SHALL have port engine_reset, output, 1 bit: holds the ball/paddle datapath at its serve position.
REQ-011 The block SHALL have port engine_step, output, 1 bit: one-cycle enable that advances the datapath by one frame.
REQ-012 The block SHALL have port serve_dir, output, 1 bit: direction of the next serve; 0 = toward left, 1 = toward right.
REQ-013 The block SHALL have ports score_left and score_right, output, 4 bits each: the current points of each player.
REQ-014 The block SHALL have port game_over, output, 1 bit: high while in state OVER.
REQ-015 The block SHALL have port winner, output, 1 bit: 0 = left player, 1 = right player; valid only while game_over = 1.
REQ-016 The block SHALL have port state_o, output, 3 bits: state encoding IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.

Function
REQ-017 All outputs SHALL be registered; each output SHALL respond one cycle after the input that causes the change.
REQ-018 IDLE: engine_reset=1 and engine_step=0; when start=1, scores clear to 0, the serve counter clears, and the state goes to SERVE.
REQ-019 SERVE: engine_reset=1; the serve counter increments on each frame_tick; when the SERVE_FRAMES-th tick arrives, the state goes to PLAY and the counter clears.
REQ-020 PLAY: engine_reset=0; engine_step pulses for one cycle, one cycle after each frame_tick.
REQ-021 PLAY, miss_left alone: score_right increments, serve_dir becomes 0, and the state goes to POINT.
REQ-022 PLAY, miss_right alone: score_left increments, serve_dir becomes 1, and the state goes to POINT.
REQ-023 PLAY, both miss pulses in the same cycle: no score change, serve_dir unchanged, the state goes to SERVE.
REQ-024 PLAY, a miss and frame_tick in the same cycle: the miss takes effect and engine_step is suppressed for that frame.
REQ-025 POINT lasts exactly one cycle: if either score equals WIN_SCORE the state goes to OVER, otherwise to SERVE; engine_reset=1 in POINT.
REQ-026 OVER: engine_reset=1, game_over=1, and winner names the player whose score equals WIN_SCORE; start=1 clears the scores and goes to SERVE.
REQ-027 Miss pulses SHALL be ignored in every state other than PLAY.
REQ-028 start SHALL be ignored in SERVE, PLAY and POINT.
REQ-029 Scores SHALL saturate at 15 and SHALL never wrap.
REQ-030 The serve counter SHALL be 8 bits wide and SHALL hold its value between frame_ticks.

Reset
REQ-031 While reset=1 on a clock edge: state=IDLE, scores=0, serve counter=0, serve_dir=0, engine_reset=1, engine_step=0, game_over=0, winner=0.
REQ-032 Reset SHALL take priority over every other input, including when asserted in mid-serve or mid-play.

Configuration
REQ-033 When macro PONG_CTRL_PAUSE_EN is defined: pause=1 in PLAY suppresses engine_step and ignores misses; pause=1 in SERVE freezes the serve counter; the state is held and resumes unchanged when pause=0.
REQ-034 When PONG_CTRL_PAUSE_EN is undefined: the pause port exists but is ignored, and no pause logic is synthesized.

Verification
REQ-035 Reset, then start=1 for 1 cycle -> state_o=1, engine_reset=1; after 60 frame_ticks -> state_o=2, engine_reset=0.
REQ-036 In PLAY, 3 frame_ticks -> exactly 3 engine_step pulses, each one cycle after its tick.
REQ-037 In PLAY, miss_left -> score_right=1, serve_dir=0, state_o sequence 3 then 1.
REQ-038 In PLAY, miss_left and miss_right in the same cycle -> scores unchanged, state_o=1 directly.
REQ-039 With WIN_SCORE=2, two miss_right events -> score_left=2, game_over=1, winner=0; then start -> scores 0, state_o=1.
REQ-040 With PONG_CTRL_PAUSE_EN defined, pause=1 in PLAY with 5 frame_ticks and a miss_left -> no engine_step, score unchanged; without the macro -> 5 steps are produced (the miss scores).
